pa_perips_intc: RTL

PA_PERIPS_INTC -- requirements
Module: pa_perips_intc

---
 rtl/pa_perips_intc_pkg.sv | 23 ++
 rtl/pa_perips_intc_if.sv | 13 +
 rtl/pa_perips_intc_arb.sv | 27 ++
 rtl/pa_perips_intc.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pa_perips_intc_pkg.sv
// Shared constants for the interrupt controller: bus widths, register map, ID/priority widths.
// PRIO/THRESH offsets are only decoded when INTC_PRIORITY_EN is defined.
package pa_perips_intc_pkg;

  localparam int          DATA_BUS_WIDTH = 32;
  localparam logic [31:0] ZERO_WORD      = 32'h0;
  localparam int          INTC_SRC_MAX   = 8;
  localparam int          INTC_ID_W      = 4;
  localparam int          INTC_PRIO_W    = 3;

  localparam logic [7:0] INTC_REG_CR     = 8'h00;
  localparam logic [7:0] INTC_REG_IE     = 8'h04;
  localparam logic [7:0] INTC_REG_IP     = 8'h08;
  localparam logic [7:0] INTC_REG_CLAIM  = 8'h0C;
  localparam logic [7:0] INTC_REG_IS     = 8'h10;
  localparam logic [7:0] INTC_REG_THRESH = 8'h14;
  localparam logic [7:0] INTC_REG_PRIO0  = 8'h20;

  function automatic logic [7:0] intc_prio_addr(input int idx);
    return INTC_REG_PRIO0 + 8'(idx * 4);
  endfunction

endpackage

// File: rtl/pa_perips_intc_if.sv
// Register bus between a core-side master and the interrupt controller.
interface pa_perips_intc_if;
  import pa_perips_intc_pkg::*;

  logic [7:0]                addr_i;
  logic                      data_rd_i;
  logic                      data_we_i;
  logic [DATA_BUS_WIDTH-1:0] data_i;
  logic [DATA_BUS_WIDTH-1:0] data_o;

  modport master (output addr_i, data_rd_i, data_we_i, data_i, input data_o);
  modport slave  (input addr_i, data_rd_i, data_we_i, data_i, output data_o);
endinterface

// File: rtl/pa_perips_intc_arb.sv
// Combinational arbiter: highest priority wins, lowest index breaks ties; ID 0 means no winner.
module pa_perips_intc_arb
  import pa_perips_intc_pkg::*;
#(
  parameter int SRC_NUM = INTC_SRC_MAX
) (
  input  logic [SRC_NUM-1:0]             elig_i,
  input  logic [SRC_NUM*INTC_PRIO_W-1:0] prio_i,
  output logic [INTC_ID_W-1:0]           win_id_o
);

  logic [INTC_PRIO_W-1:0] best_prio;

  // Strict '>' keeps the earlier (lower index) source on equal priority.
  always_comb begin
    win_id_o  = '0;
    best_prio = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (elig_i[i] && ((win_id_o == '0) ||
          (prio_i[i*INTC_PRIO_W +: INTC_PRIO_W] > best_prio))) begin
        win_id_o  = INTC_ID_W'(i + 1);
        best_prio = prio_i[i*INTC_PRIO_W +: INTC_PRIO_W];
      end
    end
  end

endmodule

// File: rtl/pa_perips_intc.sv
// Level-input interrupt controller with edge-latched pending, claim/complete and in-service tracking.
// Define INTC_PRIORITY_EN to add per-source PRIO registers and a THRESH register.
module pa_perips_intc
  import pa_perips_intc_pkg::*;
#(
  parameter int SRC_NUM = INTC_SRC_MAX
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pa_perips_intc_if.slave    bus,
  input  logic [SRC_NUM-1:0] src_irq_i,
  output logic               irq_o
);

  logic                           cr_q, cr_d;
  logic [SRC_NUM-1:0]             ie_q, ie_d, ip_q, ip_d, is_q, is_d;
  logic [SRC_NUM-1:0]             s1_q, s2_q, s3_q;
  logic                           irq_q, irq_d;
  logic [DATA_BUS_WIDTH-1:0]      data_q, data_d, rdata;
  logic [SRC_NUM-1:0]             rise, elig, prio_ok, claim_mask, cmpl_mask;
  logic [SRC_NUM*INTC_PRIO_W-1:0] prio_vec;
  logic [INTC_ID_W-1:0]           win_id;
  logic                           claim_rd, claim_wr;

  assign rise = s2_q & ~s3_q;
  assign elig = ip_q & ie_q & ~is_q & prio_ok;

`ifdef INTC_PRIORITY_EN
  logic [INTC_PRIO_W-1:0] prio_q [SRC_NUM];
  logic [INTC_PRIO_W-1:0] prio_d [SRC_NUM];
  logic [INTC_PRIO_W-1:0] thresh_q, thresh_d;

  always_comb begin
    prio_d   = prio_q;
    thresh_d = thresh_q;
    if (bus.data_we_i && (bus.addr_i == INTC_REG_THRESH)) thresh_d = bus.data_i[INTC_PRIO_W-1:0];
    for (int i = 0; i < SRC_NUM; i++) begin
      if (bus.data_we_i && (bus.addr_i == intc_prio_addr(i))) prio_d[i] = bus.data_i[INTC_PRIO_W-1:0];
      prio_ok[i]                            = prio_q[i] > thresh_q;
      prio_vec[i*INTC_PRIO_W +: INTC_PRIO_W] = prio_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_q   <= '{default: '0};
      thresh_q <= '0;
    end else begin
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
    end
  end
`else
  assign prio_ok  = '1;
  assign prio_vec = '0;
`endif

  pa_perips_intc_arb #(.SRC_NUM(SRC_NUM)) u_arb (
    .elig_i   (elig),
    .prio_i   (prio_vec),
    .win_id_o (win_id)
  );

  // A claim and a fresh edge on the same source: set wins, so IP stays high.
  always_comb begin
    claim_rd = bus.data_rd_i && (bus.addr_i == INTC_REG_CLAIM) && cr_q;
    claim_wr = bus.data_we_i && (bus.addr_i == INTC_REG_CLAIM);
    for (int i = 0; i < SRC_NUM; i++) begin
      claim_mask[i] = claim_rd && (win_id == INTC_ID_W'(i + 1));
      cmpl_mask[i]  = claim_wr && (bus.data_i == DATA_BUS_WIDTH'(i + 1));
    end

    cr_d = cr_q;
    ie_d = ie_q;
    if (bus.data_we_i && (bus.addr_i == INTC_REG_CR)) cr_d = bus.data_i[0];
    if (bus.data_we_i && (bus.addr_i == INTC_REG_IE)) ie_d = bus.data_i[SRC_NUM-1:0];
    ip_d  = (ip_q & ~claim_mask) | rise;
    is_d  = (is_q & ~cmpl_mask) | claim_mask;
    irq_d = cr_q && (|elig);

    rdata = ZERO_WORD;
    case (bus.addr_i)
      INTC_REG_CR:     rdata = DATA_BUS_WIDTH'(cr_q);
      INTC_REG_IE:     rdata = DATA_BUS_WIDTH'(ie_q);
      INTC_REG_IP:     rdata = DATA_BUS_WIDTH'(ip_q);
      INTC_REG_CLAIM:  rdata = cr_q ? DATA_BUS_WIDTH'(win_id) : ZERO_WORD;
      INTC_REG_IS:     rdata = DATA_BUS_WIDTH'(is_q);
`ifdef INTC_PRIORITY_EN
      INTC_REG_THRESH: rdata = DATA_BUS_WIDTH'(thresh_q);
      default: begin
        for (int i = 0; i < SRC_NUM; i++)
          if (bus.addr_i == intc_prio_addr(i)) rdata = DATA_BUS_WIDTH'(prio_q[i]);
      end
`else
      default:         rdata = ZERO_WORD;
`endif
    endcase
    data_d = bus.data_rd_i ? rdata : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cr_q   <= 1'b0;
      ie_q   <= '0;
      ip_q   <= '0;
      is_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      irq_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cr_q   <= cr_d;
      ie_q   <= ie_d;
      ip_q   <= ip_d;
      is_q   <= is_d;
      s1_q   <= src_irq_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      irq_q  <= irq_d;
      data_q <= data_d;
    end
  end

  assign bus.data_o = data_q;
  assign irq_o      = irq_q;

endmodule
